// File: rtl/fifo_arb_pkg.sv
// Shared encodings for the FIFO read arbiter: FSM states and status levels.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        HOLD = 2'd2,
        PEEK = 2'd3
    } state_e;

    localparam logic [2:0] ST_EMPTY  = 3'd0;
    localparam logic [2:0] ST_FULL   = 3'd5;
    localparam logic [2:0] ST_STARVE = 3'd6;

endpackage

// File: rtl/fifo_arb_pick.sv
// Combinational winner pick: highest 3-bit priority wins, ties go to the
// first channel found scanning upward from rr_ptr.
module fifo_arb_pick
    import fifo_arb_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [3*NCH-1:0] prio,
    input  logic [CHW-1:0]   rr_ptr,
    output logic [CHW-1:0]   winner,
    output logic             hit
);

    logic [2:0]     best;
    logic [CHW-1:0] idx;

    // Strict '>' keeps the earliest channel in scan order on a tie.
    always_comb begin
        best   = ST_EMPTY;
        winner = rr_ptr;
        hit    = 1'b0;
        idx    = rr_ptr;
        for (int k = 0; k < NCH; k++) begin
            idx = rr_ptr + CHW'(k);
            if (prio[3*int'(idx) +: 3] > best) begin
                best   = prio[3*int'(idx) +: 3];
                winner = idx;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Consumer-side arbiter for a bank of FIFOs: pops the fullest channel with
// round-robin tie break and a starvation guard, plus a non-popping peek port.
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int STARVE_LIM = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3*NCH-1:0]   fifo_status_i,
    input  logic [WIDTH*NCH-1:0] rd_data_i,
    output logic [NCH-1:0]     rd_en_o,
    output logic [NCH-1:0]     rd_only_o,
    input  logic               arb_en_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   out_data_o,
    output logic [CHW-1:0]     out_ch_o,
    input  logic               peek_req_i,
    input  logic [CHW-1:0]     peek_ch_i,
    output logic               peek_valid_o,
    output logic [WIDTH-1:0]   peek_data_o,
    output logic               peek_empty_o,
    output state_e             dbg_state
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

    state_e          state, state_nxt;
    logic [CHW-1:0]  grant_q;
    logic [CHW-1:0]  peek_ch_q;
    logic [CHW-1:0]  rr_ptr;
    logic [SW-1:0]   starve [NCH];
    logic [2:0]      sts    [NCH];
    logic [3*NCH-1:0] prio;
    logic [CHW-1:0]  winner;
    logic            hit;

    assign dbg_state = state;

    // Codes 6/7 are undefined on the status bus; treat them as full so they
    // can never masquerade as a starvation boost.
    always_comb begin
        prio = '0;
        for (int c = 0; c < NCH; c++) begin
            sts[c] = (fifo_status_i[3*c +: 3] > ST_FULL) ? ST_FULL : fifo_status_i[3*c +: 3];
            prio[3*c +: 3] = (starve[c] == LIM && sts[c] != ST_EMPTY) ? ST_STARVE : sts[c];
        end
    end

    fifo_arb_pick #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_pick (
        .prio   (prio),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .hit    (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A request still high during the peek_valid_o cycle is the one just
    // answered, so it is not taken again.
    always_comb begin
        state_nxt = state;
        rd_en_o   = '0;
        rd_only_o = '0;
        case (state)
            IDLE: begin
                if (peek_req_i && !peek_valid_o) state_nxt = PEEK;
                else if (arb_en_i && hit)        state_nxt = POP;
            end
            POP: begin
                rd_en_o[grant_q] = 1'b1;
                state_nxt        = HOLD;
            end
            HOLD: begin
                if (out_ready_i) state_nxt = IDLE;
            end
            PEEK: begin
                if (sts[peek_ch_q] != ST_EMPTY) begin
                    rd_en_o[peek_ch_q]   = 1'b1;
                    rd_only_o[peek_ch_q] = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= '0;
            peek_ch_q    <= '0;
            rr_ptr       <= '0;
            out_valid_o  <= 1'b0;
            out_data_o   <= '0;
            out_ch_o     <= '0;
            peek_valid_o <= 1'b0;
            peek_data_o  <= '0;
            peek_empty_o <= 1'b0;
            for (int c = 0; c < NCH; c++) starve[c] <= '0;
        end else begin
            peek_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_nxt == POP)  grant_q   <= winner;
                    if (state_nxt == PEEK) peek_ch_q <= peek_ch_i;
                end
                POP: begin
                    out_data_o  <= rd_data_i[int'(grant_q)*WIDTH +: WIDTH];
                    out_ch_o    <= grant_q;
                    out_valid_o <= 1'b1;
                    rr_ptr      <= grant_q + CHW'(1);
                    for (int c = 0; c < NCH; c++) begin
                        if (CHW'(c) == grant_q)        starve[c] <= '0;
                        else if (sts[c] == ST_EMPTY)   starve[c] <= '0;
                        else if (starve[c] != LIM)     starve[c] <= starve[c] + SW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready_i) out_valid_o <= 1'b0;
                end
                PEEK: begin
                    peek_valid_o <= 1'b1;
                    if (sts[peek_ch_q] != ST_EMPTY) begin
                        peek_data_o  <= rd_data_i[int'(peek_ch_q)*WIDTH +: WIDTH];
                        peek_empty_o <= 1'b0;
                    end else begin
                        peek_data_o  <= '0;
                        peek_empty_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
Consumer-side arbiter for a bank of NCH synchronous FIFO controllers. Issues per-channel read enables and read-only strobes, and uses each FIFO's 3-bit fill status to pick the fullest channel. Ties are broken round-robin, and a starvation guard prevents any channel from being skipped indefinitely. Popped words go downstream on a valid/ready stream, and a side port lets a client peek at a channel head without popping it.

Parameters:
WIDTH, 32, data bit width per FIFO word
NCH, 4, number of FIFO channels (power of two, 2..8)
CHW, 2, channel index width, equal to log2(NCH)
STARVE_LIM, 8, number of grants to other channels a non-empty channel may lose before it is forced to top priority

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fifo_status_i  in  3*NCH  per-channel status, slice [3c+2:3c]; 0 empty, 1..4 quarter levels, 5 full
rd_data_i  in  WIDTH*NCH  per-channel head word; combinational read at that FIFO's rd_addr
rd_en_o  out  NCH  per-channel read enable
rd_only_o  out  NCH  per-channel read-only qualifier (1 = peek, no pop)
arb_en_i  in  1  enables new pop arbitration
out_valid_o  out  1  popped word valid
out_ready_i  in  1  downstream accepts word
out_data_o  out  WIDTH  popped word
out_ch_o  out  CHW  source channel of out_data_o
peek_req_i  in  1  peek request; held high until peek_valid_o
peek_ch_i  in  CHW  channel to peek
peek_valid_o  out  1  one-cycle pulse; peek_data_o and peek_empty_o are valid in this cycle
peek_data_o  out  WIDTH  head word of the peeked channel
peek_empty_o  out  1  peeked channel was empty; peek_data_o is 0 in that case

Behaviour:
- Reset: state IDLE. rd_en_o, rd_only_o, out_valid_o, out_data_o, out_ch_o, peek_valid_o, peek_data_o and peek_empty_o all 0. Round-robin pointer 0, all starvation counters 0. Reset asserted mid-operation aborts immediately; a word not yet handed off downstream is dropped, but a word already popped from its FIFO is not re-fetched.
- States: IDLE, POP, HOLD, PEEK.
- IDLE:
  - If peek_req_i is high, register peek_ch_i and go to PEEK. Peek wins over a pop in the same cycle.
  - Otherwise, if arb_en_i is high and any status is non-zero, register the winner and go to POP.
  - Otherwise stay in IDLE.
- Winner selection:
  - Effective priority = 6 if the channel's starvation counter equals STARVE_LIM and its status is non-zero; otherwise its raw status.
  - The highest effective priority wins.
  - Ties go to the first channel at or after rr_ptr, scanning upward modulo NCH.
- POP (1 cycle):
  - rd_en_o[g] = 1, rd_only_o[g] = 0; all other bits 0.
  - At the clock edge, capture rd_data_i[g] into out_data_o and g into out_ch_o, set out_valid_o = 1, set rr_ptr = (g+1) mod NCH, then go to HOLD.
  - Starvation counters update at the same edge. Counter g clears to 0. Every other channel with non-zero status increments, saturating at STARVE_LIM. Channels with zero status clear to 0.
- HOLD: out_valid_o stays 1 and out_data_o stays stable until out_ready_i is high. On that edge out_valid_o clears and the state goes to IDLE.
- Throughput is one word per 3 cycles with out_ready_i tied high. A status change caused by the pop is visible by HOLD, so IDLE never sees a stale count.
- PEEK (1 cycle):
  - If status[c] is non-zero: rd_en_o[c] = 1, rd_only_o[c] = 1; at the edge capture rd_data_i[c] into peek_data_o and set peek_empty_o = 0.
  - If status[c] is 0: assert no rd_en; set peek_data_o = 0 and peek_empty_o = 1.
  - peek_valid_o is 1 for exactly the next cycle, and the state returns to IDLE.
  - rr_ptr and the starvation counters are unchanged by a peek.
- Invariants:
  - rd_en_o is one-hot or zero.
  - rd_only_o[c] = 1 only when rd_en_o[c] = 1.
  - A pop is never issued to a channel whose status is 0.
  - peek_req_i outside IDLE is held off until IDLE, since the requester keeps it high.
- Widths: starvation counters are clog2(STARVE_LIM+1) bits. Priority comparison is 3 bits unsigned.

Decomposition:
- Package fifo_arb_pkg holds the state encoding (IDLE, POP, HOLD, PEEK) and the status constants ST_EMPTY = 0, ST_FULL = 5, ST_STARVE = 6.
- One sub-module, fifo_arb_pick: purely combinational. Inputs are the effective priorities and rr_ptr; outputs are the winner index and a hit flag.

Test Plan:
- After reset, all status 0 and arb_en_i = 1: rd_en_o stays 0 and out_valid_o stays 0 for 20 cycles.
- Status = {ch0:1, ch1:3, ch2:5, ch3:0}, rd_data ch2 = 0xA5A5_0002, out_ready_i = 1: rd_en_o = 4'b0100 with rd_only_o = 0; one cycle later out_data_o = 0xA5A5_0002, out_ch_o = 2, out_valid_o = 1.
- All four channels at status 2 held constant: grants occur in order 0, 1, 2, 3, 0.
- Status ch0 = 5 constant, ch1 = 1, STARVE_LIM = 8: after 8 consecutive grants to ch0, the next grant goes to ch1; then ch0 resumes.
- out_ready_i low for 10 cycles during HOLD: out_valid_o and out_data_o stay stable, and no rd_en_o is asserted. Raising out_ready_i for one cycle returns the block to IDLE.
- peek_req_i with ch3 at status 2 and data 0x1234_5678: rd_en_o = 4'b1000 with rd_only_o = 4'b1000; next cycle peek_valid_o = 1, peek_data_o = 0x1234_5678, and rr_ptr is unchanged. Peek of empty ch1: peek_empty_o = 1, peek_data_o = 0, no rd_en_o. Reset asserted in POP: all outputs are 0 in the same cycle.
